dac_update_sched: RTL

Scheduler that sequences the 8-channel SPI DAC datapath.
- Collects per-channel 16-bit update requests into shadow registers.
- Arbitrates pending channels round-robin.
- Issues one 24-bit SPI frame per update to a frame-level SPI master: 8-bit address plus 16-bit data.
- Sends the 24-bit DAC configuration frame after every reset and on request; configuration always has priority over channel updates.

---
 rtl/dac_sched_pkg.sv | 23 ++
 rtl/dac_update_sched_rr_arbiter.sv | 40 ++++
 rtl/dac_update_sched.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dac_sched_pkg.sv
// Shared definitions for the DAC update scheduler.
//   state_t       : scheduler FSM encoding (IDLE=0 .. GAP=4)
//   FRAME_W       : SPI frame width for the default address/data widths
//   BASE_ADDR_DEF : default DAC address of channel 0
//   CFG_WORD_DEF  : default DAC configuration frame
package dac_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  localparam int AW_DEF  = 8;
  localparam int DW_DEF  = 16;
  localparam int FRAME_W = AW_DEF + DW_DEF;

  localparam logic [AW_DEF-1:0]  BASE_ADDR_DEF = 8'h14;
  localparam logic [FRAME_W-1:0] CFG_WORD_DEF  = 24'h030A2C;

endpackage

// File: rtl/dac_update_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       in  NUM_CH   request vector
//   ptr       in  IW       highest-priority index this round
//   gnt_oh    out NUM_CH   one-hot grant
//   gnt_idx   out IW       binary index of the grant
//   gnt_valid out 1        at least one request was present
// Search starts at ptr and wraps; NUM_CH is a power of two so the
// index wraps by simple truncation.
module rr_arbiter #(
  parameter int NUM_CH = 8,
  parameter int IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt_oh,
  output logic [IW-1:0]     gnt_idx,
  output logic              gnt_valid
);

  logic [IW-1:0] idx_s;

  // Scan from ptr upward (modulo NUM_CH); first request found wins.
  always_comb begin
    gnt_oh    = {NUM_CH{1'b0}};
    gnt_idx   = {IW{1'b0}};
    gnt_valid = 1'b0;
    idx_s     = {IW{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      idx_s = ptr + IW'(k);
      if (!gnt_valid && req[idx_s]) begin
        gnt_valid      = 1'b1;
        gnt_idx        = idx_s;
        gnt_oh[idx_s]  = 1'b1;
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/dac_update_sched.sv
// Update scheduler for an NUM_CH-channel SPI DAC.
// Collects per-channel updates into a shadow bank, arbitrates pending
// channels round-robin and hands one {address, data} frame at a time to a
// frame-level SPI master. The configuration frame is sent after every reset
// and on cfg_reload, always ahead of channel updates.
//   clk, rst_n   clock, asynchronous active-low reset
//   upd_valid/upd_data/upd_ready  per-channel update handshake
//   cfg_reload   pulse: re-send CFG_WORD
//   spi_req/spi_frame/spi_ack/spi_done  frame interface to SPI master
//   busy         scheduler not idle
//   cfg_done     a config frame has completed since reset
//   cur_ch       channel of the last granted frame
//   ovr_cnt      saturating count of coalesced overwrites
module dac_update_sched
  import dac_sched_pkg::*;
#(
  parameter int                  NUM_CH    = 8,
  parameter int                  DW        = 16,
  parameter int                  AW        = 8,
  parameter logic [AW-1:0]       BASE_ADDR = BASE_ADDR_DEF,
  parameter logic [AW+DW-1:0]    CFG_WORD  = CFG_WORD_DEF,
  parameter int                  GAP_CYC   = 4,
  parameter int                  COALESCE  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         upd_valid,
  input  logic [NUM_CH*DW-1:0]      upd_data,
  output logic [NUM_CH-1:0]         upd_ready,
  input  logic                      cfg_reload,
  output logic                      spi_req,
  output logic [AW+DW-1:0]          spi_frame,
  input  logic                      spi_ack,
  input  logic                      spi_done,
  output logic                      busy,
  output logic                      cfg_done,
  output logic [$clog2(NUM_CH)-1:0] cur_ch,
  output logic [15:0]               ovr_cnt
);

  localparam int            FW      = AW + DW;
  localparam int            IW      = $clog2(NUM_CH);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [7:0]    GAP_END = 8'(GAP_CYC - 1);

  // Saturating add of this cycle's overwrite count.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {12'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  state_t               state_r, state_nxt_s;
  logic [DW-1:0]        shadow_r [NUM_CH];
  logic [NUM_CH-1:0]    pend_r, hs_s, clr_s, upd_ready_s;
  logic                 cfg_pend_r, cfg_pend_nxt_s;
  logic [IW-1:0]        ptr_r, ptr_nxt_s;
  logic [7:0]           gap_cnt_r;
  logic                 is_cfg_r, is_cfg_nxt_s;
  logic                 spi_req_r, spi_req_nxt_s;
  logic [FW-1:0]        spi_frame_r, frame_nxt_s;
  logic                 cfg_done_r, cfg_done_nxt_s;
  logic [IW-1:0]        cur_ch_r, cur_ch_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic [15:0]          ovr_cnt_r;
  logic [4:0]           ovr_inc_s;
  logic [NUM_CH-1:0]    gnt_oh_s;
  logic [IW-1:0]        gnt_idx_s;
  logic                 gnt_valid_s;
  logic [AW-1:0]        addr_s;

  rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
    .req       (pend_r),
    .ptr       (ptr_r),
    .gnt_oh    (gnt_oh_s),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  // In coalescing mode a channel always accepts; otherwise it stalls while pending.
  assign upd_ready_s = (COALESCE != 0) ? {NUM_CH{1'b1}} : ~pend_r;
  assign hs_s        = upd_valid & upd_ready_s;
  assign addr_s      = BASE_ADDR + AW'(gnt_idx_s);

  // Count handshakes that land on an already-pending channel.
  always_comb begin
    ovr_inc_s = 5'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      ovr_inc_s = ovr_inc_s + 5'(hs_s[k] & pend_r[k]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic. IDLE also looks at this cycle's handshakes so a
  // fresh update reaches ARB on the same edge that captures it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_pend_r || cfg_reload || (|pend_r) || (|hs_s)) state_nxt_s = ST_ARB;
        else                                                    state_nxt_s = ST_IDLE;
      end
      ST_ARB: begin
        if (cfg_pend_r || gnt_valid_s) state_nxt_s = ST_ISSUE;
        else                           state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (spi_req_r && spi_ack) state_nxt_s = ST_WAIT_DONE;
        else                      state_nxt_s = ST_ISSUE;
      end
      ST_WAIT_DONE: begin
        if (spi_done) state_nxt_s = ST_GAP;
        else          state_nxt_s = ST_WAIT_DONE;
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_END) state_nxt_s = ST_IDLE;
        else                      state_nxt_s = ST_GAP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs and grant side effects.
  always_comb begin
    spi_req_nxt_s  = 1'b0;
    frame_nxt_s    = spi_frame_r;
    cur_ch_nxt_s   = cur_ch_r;
    ptr_nxt_s      = ptr_r;
    is_cfg_nxt_s   = is_cfg_r;
    clr_s          = {NUM_CH{1'b0}};
    cfg_done_nxt_s = cfg_done_r;
    case (state_r)
      ST_ARB: begin
        if (cfg_pend_r) begin
          frame_nxt_s  = CFG_WORD;
          is_cfg_nxt_s = 1'b1;
        end else if (gnt_valid_s) begin
          frame_nxt_s  = {addr_s, shadow_r[gnt_idx_s]};
          clr_s        = gnt_oh_s;
          cur_ch_nxt_s = gnt_idx_s;
          ptr_nxt_s    = gnt_idx_s + IDX_ONE;
          is_cfg_nxt_s = 1'b0;
        end else begin
          is_cfg_nxt_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        // Ack only counts once the request is actually visible to the master.
        spi_req_nxt_s = ~(spi_req_r & spi_ack);
      end
      ST_WAIT_DONE: begin
        if (spi_done && is_cfg_r) cfg_done_nxt_s = 1'b1;
        else                      cfg_done_nxt_s = cfg_done_r;
      end
      default: spi_req_nxt_s = 1'b0;
    endcase
    // A reload in the ARB cycle that serves the config still leaves one pending.
    if (cfg_reload)                           cfg_pend_nxt_s = 1'b1;
    else if (state_r == ST_ARB && cfg_pend_r) cfg_pend_nxt_s = 1'b0;
    else                                      cfg_pend_nxt_s = cfg_pend_r;
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_req_r   <= 1'b0;
      spi_frame_r <= {FW{1'b0}};
      cur_ch_r    <= {IW{1'b0}};
      ptr_r       <= {IW{1'b0}};
      is_cfg_r    <= 1'b0;
      cfg_pend_r  <= 1'b1;
      cfg_done_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      spi_req_r   <= spi_req_nxt_s;
      spi_frame_r <= frame_nxt_s;
      cur_ch_r    <= cur_ch_nxt_s;
      ptr_r       <= ptr_nxt_s;
      is_cfg_r    <= is_cfg_nxt_s;
      cfg_pend_r  <= cfg_pend_nxt_s;
      cfg_done_r  <= cfg_done_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Inter-frame gap counter: restarts when leaving WAIT_DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      gap_cnt_r <= 8'd0;
    else if (state_r == ST_GAP)      gap_cnt_r <= gap_cnt_r + 8'd1;
    else                             gap_cnt_r <= 8'd0;
  end

  // Shadow bank and pending flags; a new handshake beats a same-cycle grant clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) shadow_r[i] <= {DW{1'b0}};
    end else begin
      pend_r <= (pend_r & ~clr_s) | hs_s;
      for (int i = 0; i < NUM_CH; i++) begin
        if (hs_s[i]) shadow_r[i] <= upd_data[i*DW +: DW];
      end
    end
  end

  // Saturating overwrite counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_cnt_r <= 16'd0;
    else        ovr_cnt_r <= sat_add(ovr_cnt_r, ovr_inc_s);
  end

  assign upd_ready = upd_ready_s;
  assign spi_req   = spi_req_r;
  assign spi_frame = spi_frame_r;
  assign busy      = busy_r;
  assign cfg_done  = cfg_done_r;
  assign cur_ch    = cur_ch_r;
  assign ovr_cnt   = ovr_cnt_r;

endmodule
